// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared constants and state types for the Knight link host
package remote_comm_pkg;
  localparam int         BAUD_DIV_DEF = 434;
  localparam logic [7:0] POS_ACK      = 8'hA5;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} cmd_state_t;
  typedef enum logic       {TX_IDLE, TX_BUSY} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_BUSY} rx_state_t;
endpackage

// File: rtl/remote_comm_uart.sv
// rtl/remote_comm_uart.sv - 8N1 UART transceiver with independent TX and RX paths
module uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  input  logic [7:0] tx_data,
  input  logic       trmt,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy
);
  localparam int              BW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]   HALF_LAST = BW'(BAUD_DIV / 2 - 1);

  tx_state_t     r_tx_state;
  logic [9:0]    r_tx_shift;
  logic [BW-1:0] r_tx_baud;
  logic [3:0]    r_tx_bit;
  logic          w_tx_bit_end;

  // TX is the LSB of a frame shifter that refills with ones, so idle is high for free
  assign w_tx_bit_end = (r_tx_baud == BAUD_LAST);
  assign tx_done      = (r_tx_state == TX_BUSY) && w_tx_bit_end && (r_tx_bit == 4'd9);
  assign TX           = r_tx_shift[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_shift <= '1;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
    end else if (trmt) begin
      r_tx_state <= TX_BUSY;
      r_tx_shift <= {1'b1, tx_data, 1'b0};
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
    end else if (r_tx_state == TX_BUSY) begin
      if (w_tx_bit_end) begin
        r_tx_baud  <= '0;
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        if (r_tx_bit == 4'd9) r_tx_state <= TX_IDLE;
        else                  r_tx_bit   <= r_tx_bit + 4'd1;
      end else begin
        r_tx_baud <= r_tx_baud + 1'b1;
      end
    end
  end

  logic          r_rx_ff1, r_rx_ff2, r_rx_ff3;
  rx_state_t     r_rx_state;
  logic [BW-1:0] r_rx_baud;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_rdy;
  logic          w_rx_start, w_rx_sample, w_rx_done;

  assign w_rx_start  = (r_rx_state == RX_IDLE) && r_rx_ff3 && !r_rx_ff2;
  assign w_rx_sample = (r_rx_state == RX_BUSY) &&
                       (r_rx_baud == ((r_rx_bit == 4'd0) ? HALF_LAST : BAUD_LAST));
  assign w_rx_done   = w_rx_sample && (r_rx_bit == 4'd9);
  assign rx_data     = r_rx_data;
  assign rx_rdy      = r_rx_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_ff1 <= 1'b1;
      r_rx_ff2 <= 1'b1;
      r_rx_ff3 <= 1'b1;
    end else begin
      r_rx_ff1 <= RX;
      r_rx_ff2 <= r_rx_ff1;
      r_rx_ff3 <= r_rx_ff2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_rdy   <= 1'b0;
    end else begin
      if (w_rx_start) begin
        r_rx_state <= RX_BUSY;
        r_rx_baud  <= '0;
        r_rx_bit   <= '0;
      end else if (r_rx_state == RX_BUSY) begin
        if (w_rx_sample) begin
          r_rx_baud <= '0;
          // A start bit that is high at mid-bit was only a glitch
          if (r_rx_bit == 4'd0 && r_rx_ff2) begin
            r_rx_state <= RX_IDLE;
          end else if (r_rx_bit == 4'd9) begin
            r_rx_state <= RX_IDLE;
            r_rx_data  <= r_rx_shift;
          end else begin
            if (r_rx_bit != 4'd0) r_rx_shift <= {r_rx_ff2, r_rx_shift[7:1]};
            r_rx_bit <= r_rx_bit + 4'd1;
          end
        end else begin
          r_rx_baud <= r_rx_baud + 1'b1;
        end
      end
      if (w_rx_done)                     r_rx_rdy <= 1'b1;
      else if (w_rx_start || clr_rx_rdy) r_rx_rdy <= 1'b0;
    end
  end
endmodule

// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - sends a 16-bit command as two UART bytes and reports responses
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);
  cmd_state_t r_state;
  logic [7:0] r_low;
  logic       r_cmd_snt;
  logic       w_accept, w_trmt, w_tx_done;
  logic [7:0] w_tx_data;

  // trmt is combinational so the start bit leaves on the cycle after snd_cmd
  assign w_accept  = (r_state == IDLE) && snd_cmd;
  assign w_trmt    = w_accept || ((r_state == HIGH) && w_tx_done);
  assign w_tx_data = (r_state == IDLE) ? cmd[15:8] : r_low;
  assign cmd_snt   = r_cmd_snt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_low     <= '0;
      r_cmd_snt <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (snd_cmd) begin
          r_low     <= cmd[7:0];
          r_cmd_snt <= 1'b0;
          r_state   <= HIGH;
        end
        HIGH: if (w_tx_done) r_state <= LOW;
        LOW: if (w_tx_done) begin
          r_cmd_snt <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .tx_data    (w_tx_data),
    .trmt       (w_trmt),
    .tx_done    (w_tx_done),
    .rx_data    (resp),
    .rx_rdy     (resp_rdy),
    .clr_rx_rdy (w_accept)
  );
endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - directed self-checking bench for remote_comm
module tb_remote_comm;
  import remote_comm_pkg::*;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [15:0] cmd = '0;
  logic        snd_cmd = 1'b0;
  logic        TX, cmd_snt, resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Sends c, captures TX every cycle, checks each bit's value and exact duration
  task automatic tx_run(input logic [15:0] c, input bit inject);
    logic [19:0] frame;
    logic        tx_s [0:20*B-1];
    logic [7:0]  got;
    logic        prev, v;
    logic        stable;
    int          rises, first;
    frame = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
    rises = 0;
    first = -1;
    @(negedge clk);
    cmd     = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    check("snt_clr_on_send", {31'd0, cmd_snt}, 32'd0);
    prev = cmd_snt;
    for (int k = 0; k < 20*B + 8; k++) begin
      if (k < 20*B) tx_s[k] = TX;
      if (cmd_snt && !prev) begin
        rises++;
        if (first < 0) first = k;
      end
      prev = cmd_snt;
      if (inject && k == 3*B) begin
        cmd     = 16'hFFFF;
        snd_cmd = 1'b1;
      end
      if (inject && k == 3*B + 1) snd_cmd = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 20; i++) begin
      v = tx_s[i*B];
      stable = 1'b1;
      for (int j = 0; j < B; j++) if (tx_s[i*B+j] !== v) stable = 1'b0;
      check($sformatf("tx_bit%0d_%04h", i, c), {30'd0, stable, v}, {30'd0, 1'b1, frame[i]});
    end
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 8; n++) got[n] = tx_s[(b*10 + 1 + n)*B + B/2];
      check($sformatf("ref_rx_byte%0d_%04h", b, c), {24'd0, got}, {24'd0, (b == 0) ? c[15:8] : c[7:0]});
    end
    check("snt_rise_time", first, 20*B);
    check("snt_rise_count", rises, 1);
    check("tx_idle_after", {31'd0, TX}, 32'd1);
  endtask

  // Drives one 8N1 frame on RX and checks resp/resp_rdy and their timing
  task automatic rx_frame(input logic [7:0] b);
    logic [9:0] f;
    int         first;
    logic       rdy_at_b;
    f = {1'b1, b, 1'b0};
    first = -1;
    rdy_at_b = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10*B + 4; k++) begin
      if (k == B) rdy_at_b = resp_rdy;
      if (k >= B && first < 0 && resp_rdy) first = k;
      RX = (k < 10*B) ? f[k/B] : 1'b1;
      @(negedge clk);
    end
    check($sformatf("rdy_clr_start_%02h", b), {31'd0, rdy_at_b}, 32'd0);
    check($sformatf("rdy_window_%02h", b), {31'd0, (first > 9*B && first <= 9*B + B/2 + 4)}, 32'd1);
    check($sformatf("resp_rdy_%02h", b), {31'd0, resp_rdy}, 32'd1);
    check($sformatf("resp_%02h", b), {24'd0, resp}, {24'd0, b});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, TX}, 32'd1);
    check("rst_cmd_snt", {31'd0, cmd_snt}, 32'd0);
    check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
    check("rst_resp", {24'd0, resp}, 32'd0);
    rst_n = 1'b1;

    tx_run(16'h7010, 1'b0);
    tx_run(16'h2000, 1'b0);

    rx_frame(POS_ACK);
    rx_frame(8'h3C);

    @(negedge clk);
    RX = 1'b0;
    @(negedge clk);
    RX = 1'b1;
    repeat (2*B) @(negedge clk);
    check("glitch_no_rdy", {31'd0, resp_rdy}, 32'd0);
    check("glitch_resp_hold", {24'd0, resp}, 32'h3C);

    rx_frame(8'h5A);
    tx_run(16'h1234, 1'b0);
    check("rdy_clr_by_snd", {31'd0, resp_rdy}, 32'd0);
    check("resp_hold_after_snd", {24'd0, resp}, 32'h5A);

    tx_run(16'h55AA, 1'b1);

    @(negedge clk);
    cmd     = 16'h7010;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (3*B) @(negedge clk);
    check("mid_tx_low", {31'd0, TX}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", {31'd0, TX}, 32'd1);
    check("rst_mid_snt", {31'd0, cmd_snt}, 32'd0);
    rst_n = 1'b1;
    tx_run(16'hC35A, 1'b0);

    fork
      tx_run(16'hBEEF, 1'b0);
      rx_frame(8'h96);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
